// File: rtl/bram_burst.sv
// ============================================================================
// Module : bram_burst
// Brief  : Wishbone B3 slave on-chip RAM with registered-feedback
//          incrementing bursts.
// Rev    : 1.1
// ============================================================================
`default_nettype none

module bram_burst #(
  parameter int    adr_width  = 13,
  parameter int    data_width = 32,
  parameter string init_file  = ""
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [data_width-1:0]   wb_dat_i,
  input  logic [data_width/8-1:0] wb_sel_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic                    wb_ack_o,
  output logic [data_width-1:0]   wb_dat_o
);

  localparam int LANES = data_width / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int WW    = adr_width - LSB;
  localparam int DEPTH = 1 << WW;
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    ack_q;
  logic [data_width-1:0]   dat_q;
  logic [data_width-1:0]   mem [DEPTH];

  logic                    req;
  logic [WW-1:0]           idx;
  logic [WW-1:0]           idx_inc;
  logic [WW-1:0]           wrap_mask;
  logic [WW-1:0]           nxt_idx;
  logic [WW-1:0]           rd_adr;
  logic                    adr_unused;

  assign req        = wb_cyc_i & wb_stb_i;
  assign idx        = wb_adr_i[adr_width-1:LSB];
  assign adr_unused = ^{wb_adr_i[31:adr_width], wb_adr_i[LSB-1:0]};

  // Wrapping bursts only advance the low bits selected by the mask.
  always_comb begin
    idx_inc = idx + WW'(1);
    case (wb_bte_i)
      2'b01:   wrap_mask = WW'(3);
      2'b10:   wrap_mask = WW'(7);
      2'b11:   wrap_mask = WW'(15);
      default: wrap_mask = '1;
    endcase
    nxt_idx = (idx & ~wrap_mask) | (idx_inc & wrap_mask);
    rd_adr  = (state_q == S_BURST && ack_q) ? nxt_idx : idx;
  end

  // Byte-enable write per lane; read port registered straight to the bus.
  always_ff @(posedge sys_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (req && wb_we_i && ack_q && wb_sel_i[k]) begin
        mem[idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
    dat_q <= mem[rd_adr];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            ack_q   <= 1'b1;
            state_q <= (wb_cti_i == CTI_INCR) ? S_BURST : S_SINGLE;
          end
        end
        S_SINGLE: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        S_BURST: begin
          // Only a continuing incrementing beat keeps the pipeline alive.
          if (!(req && wb_cti_i == CTI_INCR)) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_burst.sv
// tb_bram_burst: scoreboard bench for bram_burst at 32- and 64-bit data widths.
// Rev 1.0
`default_nettype none

module tb_bram_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_a, cyc_b, stb, we;
  logic [31:0] adr;
  logic [63:0] dat_i;
  logic [7:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack_a, ack_b;
  logic [31:0] dat_a;
  logic [63:0] dat_b;
  bit          use64;

  always #5 clk = ~clk;

  bram_burst #(.adr_width(13), .data_width(32)) u_dut32 (
    .sys_clk(clk), .sys_rst(rst), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i[31:0]), .wb_sel_i(sel[3:0]), .wb_cti_i(cti),
    .wb_bte_i(bte), .wb_ack_o(ack_a), .wb_dat_o(dat_a)
  );

  bram_burst #(.adr_width(13), .data_width(64)) u_dut64 (
    .sys_clk(clk), .sys_rst(rst), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_cti_i(cti),
    .wb_bte_i(bte), .wb_ack_o(ack_b), .wb_dat_o(dat_b)
  );

  logic        ack_m, cyc_m;
  logic [63:0] dat_m;
  assign ack_m = use64 ? ack_b : ack_a;
  assign cyc_m = use64 ? cyc_b : cyc_a;
  assign dat_m = use64 ? dat_b : {32'h0, dat_a};

  typedef struct {
    bit          we;
    int          idx;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mdl [int];
  int          errors = 0;
  int          checks = 0;

  function automatic int lanes();
    return use64 ? 8 : 4;
  endfunction

  function automatic int words();
    return use64 ? 1024 : 2048;
  endfunction

  function automatic logic [63:0] dmask();
    return use64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference next-address rule: linear wraps at top of memory, wrap-N stays in its aligned block.
  function automatic int nxt_m(int idx, logic [1:0] b);
    int n;
    if (b == 2'b00) return (idx + 1) % words();
    n = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : 16;
    return idx - (idx % n) + ((idx + 1) % n);
  endfunction

  function automatic logic [31:0] mk_adr(int idx);
    int sh;
    sh = use64 ? 3 : 2;
    return (32'(idx) << sh) | ($urandom & 32'hFFFF_E000);
  endfunction

  task automatic mdl_wr(input int idx, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] v;
    v = mdl.exists(idx) ? mdl[idx] : 64'h0;
    for (int k = 0; k < lanes(); k++) if (s[k]) v[8*k +: 8] = d[8*k +: 8];
    mdl[idx] = v;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: every acked beat pops one expectation; reads compare data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack_m && cyc_m && stb) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack t=%0t actual=ack with empty queue required=no ack", $time);
      end else begin
        e = q.pop_front();
        if (!e.we) check($sformatf("rd_data idx=%0d", e.idx), dat_m, e.data);
      end
    end
  end

  task automatic beat(input bit w, input int idx, input logic [63:0] d, input logic [7:0] s,
                      input logic [2:0] c, input logic [1:0] b, input int expw);
    exp_t e;
    int   waits;
    e.we  = w;
    e.idx = idx;
    if (w) begin
      mdl_wr(idx, d & dmask(), s);
      e.data = '0;
    end else begin
      e.data = mdl[idx] & dmask();
    end
    q.push_back(e);
    cyc_a = !use64; cyc_b = use64; stb = 1'b1; we = w;
    adr = mk_adr(idx); dat_i = d & dmask(); sel = s; cti = c; bte = b;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ack_m) break;
      waits++;
      if (waits > 8) begin
        errors++;
        $display("FAIL ack_timeout t=%0t actual=no ack required=ack", $time);
        break;
      end
    end
    check("ack_wait", 64'(waits), 64'(expw));
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string name);
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0;
    @(negedge clk);
    check(name, 64'(ack_m), 64'h0);
    @(posedge clk); #1;
  endtask

  task automatic classic(input bit w, input int idx, input logic [63:0] d, input logic [7:0] s);
    beat(w, idx, d, s, 3'b000, 2'b00, 1);
    idle_check("classic_end_ack");
  endtask

  task automatic burst(input bit w, input int idx0, input int n, input logic [1:0] b,
                       input bit full_sel, input int drop_at);
    int          idx;
    logic [63:0] d;
    logic [7:0]  s;
    idx = idx0;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) begin
        stb = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("drop_ack", 64'(ack_m), 64'h0);
        @(posedge clk); #1;
      end
      d = {$urandom, $urandom};
      s = full_sel ? 8'hFF : 8'($urandom);
      beat(w, idx, d, s, (i == n - 1) ? 3'b111 : 3'b010, b, (i == 0 || i == drop_at) ? 1 : 0);
      idx = nxt_m(idx, b);
    end
    idle_check("burst_end_ack");
  endtask

  task automatic prefill();
    for (int blk = 0; blk < 16; blk++) burst(1'b1, blk * 16, 16, 2'b00, 1'b1, -1);
  endtask

  task automatic random_ops(input int iters);
    int          n, st;
    logic [1:0]  b;
    bit          w;
    for (int it = 0; it < iters; it++) begin
      w = 1'($urandom);
      b = 2'($urandom);
      n = 1 + $urandom_range(0, 11);
      if (n == 1) begin
        classic(w, $urandom_range(0, 255), {$urandom, $urandom}, 8'($urandom));
      end else begin
        st = (b == 2'b00) ? $urandom_range(0, 255 - n) : $urandom_range(0, 255);
        burst(w, st, n, b, 1'b0, -1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    use64 = 1'b0;
    rst = 1'b1; cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_i = '0; sel = '0; cti = '0; bte = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ack32", 64'(ack_a), 64'h0);
    check("reset_ack64", 64'(ack_b), 64'h0);
    @(posedge clk); #1;

    // ---------------- 32-bit instance ----------------
    prefill();
    classic(1'b1, 4, 64'hDEAD_BEEF, 8'h0F);
    classic(1'b0, 4, 64'h0, 8'h0F);
    classic(1'b1, 8, 64'hAAAA_AAAA, 8'h0F);
    classic(1'b1, 8, 64'h1122_3344, 8'h05);
    classic(1'b0, 8, 64'h0, 8'h0F);
    check("byte_lane_model", mdl[8] & dmask(), 64'hAA22_AA44);
    // back-to-back classic reads: second also waits exactly one cycle
    beat(1'b0, 4, 64'h0, 8'h0F, 3'b000, 2'b00, 1);
    beat(1'b0, 8, 64'h0, 8'h0F, 3'b000, 2'b00, 1);
    idle_check("b2b_end_ack");
    burst(1'b0, 64, 8, 2'b00, 1'b1, -1);
    burst(1'b1, 3, 4, 2'b01, 1'b1, -1);
    for (int i = 0; i <= 4; i++) classic(1'b0, i, 64'h0, 8'h0F);
    burst(1'b0, 69, 12, 2'b10, 1'b1, -1);
    burst(1'b0, 75, 20, 2'b11, 1'b1, -1);
    burst(1'b0, 64, 8, 2'b00, 1'b1, 3);
    random_ops(25);
    burst(1'b1, 2044, 4, 2'b00, 1'b1, -1);
    burst(1'b0, 2044, 8, 2'b00, 1'b1, -1);

    // reset while beat 3 of a write burst is on the bus
    for (int i = 0; i < 3; i++)
      beat(1'b1, 128 + i, {$urandom, $urandom}, 8'hFF, 3'b010, 2'b00, (i == 0) ? 1 : 0);
    adr = mk_adr(131); dat_i = {$urandom, $urandom} & dmask(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc_a = 1'b0; stb = 1'b0;
    mdl.delete(131);
    @(negedge clk);
    check("rst_mid_burst_ack", 64'(ack_a), 64'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) classic(1'b0, 128 + i, 64'h0, 8'h0F);

    // ---------------- 64-bit instance ----------------
    use64 = 1'b1;
    mdl.delete();
    prefill();
    burst(1'b0, 32, 8, 2'b00, 1'b1, -1);
    burst(1'b1, 1020, 4, 2'b00, 1'b1, -1);
    burst(1'b0, 1020, 8, 2'b00, 1'b1, -1);
    burst(1'b0, 35, 6, 2'b01, 1'b1, 2);
    random_ops(15);

    repeat (3) @(posedge clk);
    check("queue_drain", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
